// File: rtl/xgmii_ptp_frame_gen_if.sv
// Request/status and XGMII TX bundle of the PTPv2 event-frame generator.
// The slave side is the generator; the master side is the requester and wire consumer.
interface xgmii_ptp_frame_gen_if;
  logic        gen_req_i;
  logic [3:0]  msg_type_i;
  logic [15:0] seq_id_i;
  logic [47:0] src_mac_i;
  logic [79:0] src_port_id_i;
  logic [79:0] rtc_std_i;
  logic        gen_busy_o;
  logic        gen_done_o;
  logic [79:0] ts_o;
  logic [63:0] xge_txd_o;
  logic [7:0]  xge_txc_o;

  modport master (
    output gen_req_i, msg_type_i, seq_id_i, src_mac_i, src_port_id_i, rtc_std_i,
    input  gen_busy_o, gen_done_o, ts_o, xge_txd_o, xge_txc_o
  );

  modport slave (
    input  gen_req_i, msg_type_i, seq_id_i, src_mac_i, src_port_id_i, rtc_std_i,
    output gen_busy_o, gen_done_o, ts_o, xge_txd_o, xge_txc_o
  );
endinterface

// File: rtl/xgmii_ptp_frame_gen.sv
// Builds a PTPv2-over-Ethernet Sync/Delay_Req frame on request and drives it onto
// a 64-bit XGMII TX lane set; originTimestamp is taken from the RTC in the START word.
module xgmii_ptp_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'h011B19000000,
  parameter int          IFG_WORDS = 2
) (
  input  logic                         tx_clk,
  input  logic                         tx_rst_n,
  input  logic                         tx_clk_en_i,
  xgmii_ptp_frame_gen_if.slave         bus
);

  localparam logic [63:0] IDLE_W   = 64'h0707070707070707;
  localparam logic [63:0] START_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W   = 64'h07070707070707FD;
  localparam logic [3:0]  IFG_LAST = 4'(IFG_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_IFG} state_t;

  state_t      state_q, state_d;
  logic [2:0]  word_q, word_d;
  logic [3:0]  ifg_q, ifg_d;
  logic        type_q, type_d;
  logic [15:0] seq_q, seq_d;
  logic [47:0] mac_q, mac_d;
  logic [79:0] port_q, port_d;
  logic [79:0] ts_q, ts_d;
  logic [31:0] crc_q, crc_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [479:0] frame;
  logic [2:0]   nxt_idx;
  logic [63:0]  nxt_word;
  logic [31:0]  fcs;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Folds lanes 0..n-1 of a word into the running CRC in wire order.
  function automatic logic [31:0] crc32_lanes(input logic [31:0] c, input logic [63:0] w,
                                              input int n);
    logic [31:0] r;
    r = c;
    for (int l = 0; l < 8; l++) if (l < n) r = crc32_byte(r, w[8*l +: 8]);
    return r;
  endfunction

  function automatic logic [63:0] pick_word(input logic [479:0] f, input logic [2:0] n);
    logic [63:0] w;
    int          idx;
    w = '0;
    for (int l = 0; l < 8; l++) begin
      idx = 8 * int'(n) + l;
      if (idx < 60) w[8*l +: 8] = 8'(f >> (8 * (59 - idx)));
    end
    return w;
  endfunction

  // Frame bytes 0..59, byte 0 in the top bits.
  always_comb begin
    frame = {DST_MAC, mac_q, 16'h88F7, 7'h0, type_q, 8'h02, 16'h002C, 8'h00, 8'h00,
             16'h0000, 64'h0, 32'h0, port_q, seq_q, 7'h0, type_q,
             (type_q ? 8'h7F : 8'h00), ts_q, 16'h0000};
    nxt_idx  = (state_q == S_START) ? 3'd0 : word_q + 3'd1;
    nxt_word = pick_word(frame, nxt_idx);
    fcs      = ~crc32_lanes(crc_q, nxt_word, 4);
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ifg_d   = ifg_q;
    type_d  = type_q;
    seq_d   = seq_q;
    mac_d   = mac_q;
    port_d  = port_q;
    ts_d    = ts_q;
    crc_d   = crc_q;
    txd_d   = IDLE_W;
    txc_d   = 8'hFF;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.gen_req_i && (bus.msg_type_i[3:1] == 3'b000)) begin
          type_d  = bus.msg_type_i[0];
          seq_d   = bus.seq_id_i;
          mac_d   = bus.src_mac_i;
          port_d  = bus.src_port_id_i;
          state_d = S_START;
          txd_d   = START_W;
          txc_d   = 8'h01;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        ts_d    = bus.rtc_std_i;
        state_d = S_DATA;
        word_d  = 3'd0;
        txd_d   = nxt_word;
        txc_d   = 8'h00;
        crc_d   = crc32_lanes(32'hFFFFFFFF, nxt_word, 8);
      end
      S_DATA: begin
        if (word_q == 3'd7) begin
          state_d = S_TERM;
          txd_d   = TERM_W;
          done_d  = 1'b1;
        end else begin
          word_d = nxt_idx;
          txc_d  = 8'h00;
          // Last word: four payload bytes plus the FCS that covers them.
          if (nxt_idx == 3'd7) begin
            txd_d = {fcs, nxt_word[31:0]};
          end else begin
            txd_d = nxt_word;
            crc_d = crc32_lanes(crc_q, nxt_word, 8);
          end
        end
      end
      S_TERM: begin
        state_d = S_IFG;
        ifg_d   = 4'd1;
      end
      S_IFG: begin
        if (ifg_q == IFG_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ifg_d = ifg_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state_q <= S_IDLE;
      word_q  <= 3'd0;
      ifg_q   <= 4'd0;
      ts_q    <= '0;
      txd_q   <= IDLE_W;
      txc_q   <= 8'hFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (tx_clk_en_i) begin
      state_q <= state_d;
      word_q  <= word_d;
      ifg_q   <= ifg_d;
      ts_q    <= ts_d;
      txd_q   <= txd_d;
      txc_q   <= txc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Latched frame fields and CRC are always rewritten before use, so they carry no reset.
  always_ff @(posedge tx_clk) begin
    if (tx_clk_en_i) begin
      type_q <= type_d;
      seq_q  <= seq_d;
      mac_q  <= mac_d;
      port_q <= port_d;
      crc_q  <= crc_d;
    end
  end

  assign bus.xge_txd_o  = txd_q;
  assign bus.xge_txc_o  = txc_q;
  assign bus.gen_busy_o = busy_q;
  assign bus.gen_done_o = done_q;
  assign bus.ts_o       = ts_q;

endmodule

// File: tb/tb_xgmii_ptp_frame_gen.sv
// Scoreboard bench for xgmii_ptp_frame_gen: expected XGMII words are queued at request
// time and popped as the generator emits them; a small receive parser checks frame fields.
module tb_xgmii_ptp_frame_gen;
  localparam int          IFG_WORDS = 2;
  localparam logic [47:0] DST_MAC   = 48'h011B19000000;
  localparam logic [63:0] IDLE_W    = 64'h0707070707070707;
  localparam logic [63:0] START_W   = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W    = 64'h07070707070707FD;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic        done;
  } exp_t;

  logic tx_clk    = 1'b0;
  logic tx_rst_n  = 1'b0;
  logic tx_clk_en = 1'b1;
  logic toggle_en = 1'b0;

  xgmii_ptp_frame_gen_if bus();

  xgmii_ptp_frame_gen #(.DST_MAC(DST_MAC), .IFG_WORDS(IFG_WORDS)) dut (
    .tx_clk     (tx_clk),
    .tx_rst_n   (tx_rst_n),
    .tx_clk_en_i(tx_clk_en),
    .bus        (bus)
  );

  always #5 tx_clk = ~tx_clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   starts[$];
  int   cyc = 0;
  logic en_s = 1'b0;
  logic rs_s = 1'b0;
  int   widx = 0;
  bit   in_ifg = 1'b0;
  int   ifg_cnt = 0;
  logic [7:0] exp_b [64];
  logic [7:0] rx_b [64];
  logic [7:0] crc_buf [64];

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_calc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, crc_buf[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_frame(input logic typ, input logic [15:0] seq, input logic [47:0] mac,
                            input logic [79:0] port, input logic [79:0] ts);
    logic [47:0] dm;
    logic [31:0] crc;
    exp_t        e;
    dm = DST_MAC;
    for (int i = 0; i < 64; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      exp_b[i]     = dm[47-8*i -: 8];
      exp_b[6 + i] = mac[47-8*i -: 8];
    end
    exp_b[12] = 8'h88;
    exp_b[13] = 8'hF7;
    exp_b[14] = {7'h0, typ};
    exp_b[15] = 8'h02;
    exp_b[17] = 8'h2C;
    for (int i = 0; i < 10; i++) begin
      exp_b[34 + i] = port[79-8*i -: 8];
      exp_b[48 + i] = ts[79-8*i -: 8];
    end
    exp_b[44] = seq[15:8];
    exp_b[45] = seq[7:0];
    exp_b[46] = {7'h0, typ};
    exp_b[47] = typ ? 8'h7F : 8'h00;
    for (int i = 0; i < 60; i++) crc_buf[i] = exp_b[i];
    crc = crc_calc(60);
    exp_b[60] = crc[7:0];
    exp_b[61] = crc[15:8];
    exp_b[62] = crc[23:16];
    exp_b[63] = crc[31:24];
    e = {START_W, 8'h01, 1'b0};
    exp_q.push_back(e);
    for (int w = 0; w < 8; w++) begin
      e.d = '0;
      for (int l = 0; l < 8; l++) e.d[8*l +: 8] = exp_b[8*w + l];
      e.c    = 8'h00;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    e = {TERM_W, 8'hFF, 1'b1};
    exp_q.push_back(e);
  endtask

  // Called #1 after an edge; returns #1 after the enabled edge that sampled the request.
  task automatic send_frame(input logic [3:0] typ, input logic [15:0] seq,
                            input logic [47:0] mac, input logic [79:0] port,
                            input logic [79:0] exp_ts);
    bus.msg_type_i    = typ;
    bus.seq_id_i      = seq;
    bus.src_mac_i     = mac;
    bus.src_port_id_i = port;
    bus.gen_req_i     = 1'b1;
    if (typ < 4'd2) push_frame(typ[0], seq, mac, port, exp_ts);
    for (int k = 0; k < 4; k++) begin
      @(posedge tx_clk);
      if (tx_clk_en) break;
    end
    #1;
    bus.gen_req_i = 1'b0;
  endtask

  task automatic req_pulse(input logic [3:0] typ);
    bus.msg_type_i = typ;
    bus.gen_req_i  = 1'b1;
    @(posedge tx_clk);
    #1;
    bus.gen_req_i = 1'b0;
  endtask

  task automatic check_rx(input logic typ, input logic [15:0] seq, input logic [79:0] ts);
    logic [79:0] got_ts;
    logic [47:0] got_dst;
    logic [31:0] fcs;
    got_ts  = '0;
    got_dst = '0;
    for (int i = 0; i < 6; i++) got_dst = {got_dst[39:0], rx_b[i]};
    for (int i = 0; i < 10; i++) got_ts = {got_ts[71:0], rx_b[48 + i]};
    for (int i = 0; i < 60; i++) crc_buf[i] = rx_b[i];
    fcs = crc_calc(60);
    check_val("rx_dst", 80'(got_dst), 80'(DST_MAC));
    check_val("rx_ethertype", 80'({rx_b[12], rx_b[13]}), 80'h88F7);
    check_val("rx_msgtype", 80'(rx_b[14]), 80'(typ));
    check_val("rx_seq", 80'({rx_b[44], rx_b[45]}), 80'(seq));
    check_val("rx_ctrl", 80'(rx_b[46]), 80'(typ));
    check_val("rx_logint", 80'(rx_b[47]), typ ? 80'h7F : 80'h00);
    check_val("rx_ts", got_ts, ts);
    check_val("rx_fcs", 80'({rx_b[63], rx_b[62], rx_b[61], rx_b[60]}), 80'(fcs));
  endtask

  initial forever begin
    @(posedge tx_clk);
    #1;
    tx_clk_en = toggle_en ? ~tx_clk_en : 1'b1;
  end

  initial forever begin
    @(posedge tx_clk);
    en_s = tx_clk_en;
    rs_s = tx_rst_n;
    cyc  = cyc + 1;
  end

  // Output monitor: compares each newly produced word against the scoreboard.
  initial begin
    cur = {IDLE_W, 8'hFF, 1'b0};
    forever begin
      @(negedge tx_clk);
      if (!rs_s) begin
        exp_q.delete();
        cur    = {IDLE_W, 8'hFF, 1'b0};
        in_ifg = 1'b0;
      end else if (en_s) begin
        if (bus.xge_txc_o == 8'hFF && bus.xge_txd_o == IDLE_W) begin
          cur = {IDLE_W, 8'hFF, 1'b0};
          check_val("idle_done", 80'(bus.gen_done_o), 80'd0);
          if (in_ifg) begin
            if (bus.gen_busy_o) ifg_cnt++;
            else begin
              check_val("ifg_len", 80'(ifg_cnt), 80'(IFG_WORDS));
              in_ifg = 1'b0;
            end
          end else begin
            check_val("idle_busy", 80'(bus.gen_busy_o), 80'd0);
          end
        end else if (exp_q.size() == 0) begin
          check_val("unexpected_word", {8'h0, bus.xge_txc_o, bus.xge_txd_o},
                    {8'h0, 8'hFF, IDLE_W});
          cur = {IDLE_W, 8'hFF, 1'b0};
        end else begin
          cur = exp_q.pop_front();
          check_val("txd", 80'(bus.xge_txd_o), 80'(cur.d));
          check_val("txc", 80'(bus.xge_txc_o), 80'(cur.c));
          check_val("done", 80'(bus.gen_done_o), 80'(cur.done));
          check_val("busy", 80'(bus.gen_busy_o), 80'd1);
          if (cur.c == 8'h01) begin
            widx = 0;
            for (int i = 0; i < 64; i++) rx_b[i] = 8'h00;
            starts.push_back(cyc);
          end else if (cur.c == 8'h00) begin
            if (widx < 8)
              for (int l = 0; l < 8; l++) rx_b[8*widx + l] = bus.xge_txd_o[8*l +: 8];
            widx++;
          end else begin
            in_ifg  = 1'b1;
            ifg_cnt = 0;
          end
        end
      end else begin
        check_val("hold_txd", 80'(bus.xge_txd_o), 80'(cur.d));
        check_val("hold_txc", 80'(bus.xge_txc_o), 80'(cur.c));
        check_val("hold_done", 80'(bus.gen_done_o), 80'(cur.done));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.gen_req_i     = 1'b0;
    bus.msg_type_i    = 4'h0;
    bus.seq_id_i      = 16'h0;
    bus.src_mac_i     = 48'h0;
    bus.src_port_id_i = 80'h0;
    bus.rtc_std_i     = 80'h0;

    for (int i = 0; i < 9; i++) crc_buf[i] = 8'h31 + 8'(i);
    check_val("crc_model", 80'(crc_calc(9)), 80'hCBF43926);

    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check_val("rst_txd", 80'(bus.xge_txd_o), 80'(IDLE_W));
    check_val("rst_txc", 80'(bus.xge_txc_o), 80'hFF);
    check_val("rst_busy", 80'(bus.gen_busy_o), 80'd0);
    check_val("rst_done", 80'(bus.gen_done_o), 80'd0);
    check_val("rst_ts", bus.ts_o, 80'd0);
    @(posedge tx_clk);
    #1 tx_rst_n = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1;

    // Sync frame from the reference example
    bus.rtc_std_i = {48'h1, 32'h3B9AC9FF};
    send_frame(4'd0, 16'h1234, 48'h001122334455, 80'h0A, {48'h1, 32'h3B9AC9FF});
    @(negedge tx_clk);
    check_val("A_start_next", 80'(bus.xge_txd_o), 80'(START_W));
    check_val("A_busy_start", 80'(bus.gen_busy_o), 80'd1);
    repeat (20) @(posedge tx_clk);
    @(negedge tx_clk);
    check_rx(1'b0, 16'h1234, 80'h0000000000013B9AC9FF);
    check_val("A_ts_o", bus.ts_o, {48'h1, 32'h3B9AC9FF});

    // Delay_Req with seconds at the wrap edge
    @(posedge tx_clk);
    #1 bus.rtc_std_i = {48'hFFFFFFFFFFFF, 32'h00000001};
    send_frame(4'd1, 16'hBEEF, 48'h02AABBCCDDEE, 80'h123456789ABCDEF01122,
               {48'hFFFFFFFFFFFF, 32'h00000001});
    repeat (20) @(posedge tx_clk);
    @(negedge tx_clk);
    check_rx(1'b1, 16'hBEEF, {48'hFFFFFFFFFFFF, 32'h00000001});
    check_val("B_ts_o", bus.ts_o, {48'hFFFFFFFFFFFF, 32'h00000001});

    // Unsupported message type produces nothing
    @(posedge tx_clk);
    #1 send_frame(4'd5, 16'h5555, 48'h0, 80'h0, 80'h0);
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check_val("t5_busy", 80'(bus.gen_busy_o), 80'd0);
    repeat (10) @(posedge tx_clk);

    // Request during DATA ignored; request on last IFG word dropped; first IDLE accepted
    #1 bus.rtc_std_i = {48'h2, 32'h00000010};
    send_frame(4'd0, 16'h1111, 48'h001122334455, 80'h0B, {48'h2, 32'h00000010});
    repeat (4) @(posedge tx_clk);
    #1 req_pulse(4'd0);
    repeat (6) @(posedge tx_clk);
    #1 req_pulse(4'd0);
    send_frame(4'd0, 16'h2222, 48'h001122334455, 80'h0B, {48'h2, 32'h00000010});
    repeat (20) @(posedge tx_clk);
    @(negedge tx_clk);
    check_rx(1'b0, 16'h2222, {48'h2, 32'h00000010});
    n = starts.size();
    if (n >= 2) check_val("req_period", 80'(starts[n-1] - starts[n-2]), 80'd13);
    else check_val("req_period_starts", 80'(n), 80'd2);

    // Clock enable toggling; RTC moves while START is held
    toggle_en = 1'b1;
    repeat (4) @(posedge tx_clk);
    #1 bus.rtc_std_i = 80'hAAAA_0000_0000_1111_1111;
    send_frame(4'd0, 16'h5678, 48'h00DEADBEEF01, 80'h77, 80'h0000_0000_0042_2222_2222);
    bus.rtc_std_i = 80'hBBBB_0000_0000_3333_3333;
    @(posedge tx_clk);
    #1 bus.rtc_std_i = 80'h0000_0000_0042_2222_2222;
    @(posedge tx_clk);
    #1 bus.rtc_std_i = 80'hCCCC_0000_0000_4444_4444;
    repeat (40) @(posedge tx_clk);
    @(negedge tx_clk);
    check_rx(1'b0, 16'h5678, 80'h0000_0000_0042_2222_2222);
    check_val("T_ts_o", bus.ts_o, 80'h0000_0000_0042_2222_2222);
    toggle_en = 1'b0;
    repeat (4) @(posedge tx_clk);

    // Reset during DATA word 4 truncates the frame
    #1 bus.rtc_std_i = {48'h3, 32'h00000003};
    send_frame(4'd0, 16'h0042, 48'h001122334455, 80'h0C, {48'h3, 32'h00000003});
    repeat (5) @(posedge tx_clk);
    #1 tx_rst_n = 1'b0;
    @(posedge tx_clk);
    @(negedge tx_clk);
    check_val("mid_rst_txd", 80'(bus.xge_txd_o), 80'(IDLE_W));
    check_val("mid_rst_txc", 80'(bus.xge_txc_o), 80'hFF);
    check_val("mid_rst_busy", 80'(bus.gen_busy_o), 80'd0);
    @(posedge tx_clk);
    #1 tx_rst_n = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1 bus.rtc_std_i = {48'h1, 32'h3B9AC9FF};
    send_frame(4'd0, 16'h1234, 48'h001122334455, 80'h0A, {48'h1, 32'h3B9AC9FF});
    repeat (20) @(posedge tx_clk);
    @(negedge tx_clk);
    check_rx(1'b0, 16'h1234, {48'h1, 32'h3B9AC9FF});

    repeat (5) @(posedge tx_clk);
    @(negedge tx_clk);
    check_val("exp_q_empty", 80'(exp_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
